// File: rtl/life_engine.sv
// life_engine: ROWS x COLS Game-of-Life engine (B3/S23) with load/step/run sequencing.
// Define LIFE_WRAP_EN for a toroidal grid; otherwise cells beyond the border are dead.
module life_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stable,
  output logic                 extinct
);
  localparam int N = ROWS * COLS;
  typedef enum logic [1:0] {IDLE, PAUSE, RUN} state_t;
  state_t           r_state;
  logic [N-1:0]     r_grid;
  logic [GEN_W-1:0] r_gen_count;
  logic             r_running;
  logic             r_stable;
  logic [N-1:0]     w_next;
  logic             w_adv;
  logic             w_still;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] w_nb;
      logic [3:0] w_n;
      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_use
          localparam int NR = r + k / 3 - 1;
          localparam int NC = c + k % 3 - 1;
          localparam int J  = (k < 4) ? k : k - 1;
`ifdef LIFE_WRAP_EN
          assign w_nb[J] = r_grid[((NR + ROWS) % ROWS) * COLS + (NC + COLS) % COLS];
`else
          if (NR < 0 || NR >= ROWS || NC < 0 || NC >= COLS) begin : g_out
            assign w_nb[J] = 1'b0;
          end else begin : g_in
            assign w_nb[J] = r_grid[NR * COLS + NC];
          end
`endif
        end
      end
      assign w_n = 4'($countones(w_nb));
      assign w_next[r*COLS+c] = r_grid[r*COLS+c] ? (w_n == 4'd2 || w_n == 4'd3) : (w_n == 4'd3);
    end
  end
  assign w_adv   = (r_state == PAUSE && step) || (r_state == RUN && run);
  assign w_still = (w_next == r_grid);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grid      <= '0;
      r_gen_count <= '0;
      r_running   <= 1'b0;
      r_stable    <= 1'b0;
    end else if (load) begin
      r_state     <= PAUSE;
      r_grid      <= seed;
      r_gen_count <= '0;
      r_running   <= 1'b0;
      r_stable    <= 1'b0;
    end else if (w_adv && w_still) begin
      r_state   <= PAUSE;
      r_running <= 1'b0;
      r_stable  <= 1'b1;
    end else if (w_adv) begin
      r_grid      <= w_next;
      r_gen_count <= (&r_gen_count) ? r_gen_count : r_gen_count + GEN_W'(1);
      r_stable    <= 1'b0;
    end else if (r_state == PAUSE && run) begin
      r_state   <= RUN;
      r_running <= 1'b1;
    end else if (r_state == RUN && !run) begin
      r_state   <= PAUSE;
      r_running <= 1'b0;
    end
  end
  assign grid      = r_grid;
  assign gen_count = r_gen_count;
  assign running   = r_running;
  assign stable    = r_stable;
  assign extinct   = ~|r_grid;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of life_engine (8x8), including a GEN_W=2 instance for saturation.
module tb_life_engine;
  localparam logic [63:0] BLK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK = 64'h0000_0018_1800_0000;
  logic        clk = 1'b0, reset = 1'b0, load = 1'b0, run = 1'b0, step = 1'b0;
  logic [63:0] seed = '0;
  logic [63:0] grid, grid2;
  logic [15:0] gen;
  logic [1:0]  gen2;
  logic        running, stable, extinct, running2, stable2, extinct2;
  int          n_checks = 0, n_err = 0;
  always #5 clk = ~clk;
  life_engine #(.ROWS(8), .COLS(8), .GEN_W(16)) u_dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
    .grid(grid), .gen_count(gen), .running(running), .stable(stable), .extinct(extinct)
  );
  life_engine #(.ROWS(8), .COLS(8), .GEN_W(2)) u_sat (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
    .grid(grid2), .gen_count(gen2), .running(running2), .stable(stable2), .extinct(extinct2)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [63:0] s);
    seed = s;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  initial begin
    #1 reset = 1'b1;
    tick(2);
    chk("rst_grid", grid, 0);
    chk("rst_gen", gen, 0);
    chk("rst_running", running, 0);
    chk("rst_stable", stable, 0);
    chk("rst_extinct", extinct, 1);
    reset = 1'b0;
    tick();
    step = 1'b1; run = 1'b1;
    tick(2);
    chk("idle_grid", grid, 0);
    chk("idle_running", running, 0);
    chk("idle_gen", gen, 0);
    step = 1'b0; run = 1'b0;
    do_load(BLK_H);
    chk("load_grid", grid, BLK_H);
    chk("load_gen", gen, 0);
    chk("load_running", running, 0);
    chk("load_extinct", extinct, 0);
    step = 1'b1; tick(); step = 1'b0;
    chk("step1_grid", grid, BLK_V);
    chk("step1_gen", gen, 1);
    chk("step1_stable", stable, 0);
    step = 1'b1; tick(); step = 1'b0;
    chk("step2_grid", grid, BLK_H);
    chk("step2_gen", gen, 2);
    tick(2);
    chk("hold_grid", grid, BLK_H);
    chk("hold_gen", gen, 2);
    do_load(BLOCK);
    run = 1'b1;
    tick();
    chk("block_enter_run", running, 1);
    tick();
    chk("block_stable", stable, 1);
    chk("block_running", running, 0);
    chk("block_gen", gen, 0);
    chk("block_grid", grid, BLOCK);
    run = 1'b0;
    tick();
    do_load(64'h83);
    step = 1'b1; tick(); step = 1'b0;
`ifdef LIFE_WRAP_EN
    chk("wrap_grid", grid, 64'h0100_0000_0000_0101);
    chk("wrap_extinct", extinct, 0);
    chk("wrap_gen", gen, 1);
`else
    chk("border_grid", grid, 0);
    chk("border_extinct", extinct, 1);
    chk("border_gen", gen, 1);
    chk("border_stable0", stable, 0);
    step = 1'b1; tick(); step = 1'b0;
    chk("extinct_stable", stable, 1);
    chk("extinct_gen", gen, 1);
`endif
    do_load(BLK_H);
    run = 1'b1;
    tick();
    chk("sat_enter_run", running2, 1);
    tick(5);
    chk("run5_grid", grid, BLK_V);
    chk("run5_gen", gen, 5);
    chk("sat5_gen", gen2, 3);
    chk("sat5_grid", grid2, BLK_V);
    chk("run5_running", running, 1);
    tick();
    chk("sat6_gen", gen2, 3);
    chk("sat6_grid", grid2, BLK_H);
    chk("run6_gen", gen, 6);
    seed = BLOCK; load = 1'b1;
    tick();
    load = 1'b0; run = 1'b0;
    chk("midload_grid", grid2, BLOCK);
    chk("midload_gen", gen2, 0);
    chk("midload_running", running2, 0);
    seed = BLK_H; load = 1'b1; step = 1'b1; run = 1'b1;
    tick();
    load = 1'b0; step = 1'b0; run = 1'b0;
    chk("prio_grid", grid, BLK_H);
    chk("prio_gen", gen, 0);
    chk("prio_running", running, 0);
    chk("prio_stable", stable, 0);
    run = 1'b1;
    tick(3);
    chk("pre_rst_running", running, 1);
    chk("pre_rst_gen", gen, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_grid", grid, 0);
    chk("async_rst_gen", gen, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_stable", stable, 0);
    tick();
    reset = 1'b0;
    tick(2);
    chk("post_rst_running", running, 0);
    step = 1'b1;
    tick(2);
    chk("post_rst_grid", grid, 0);
    chk("post_rst_gen", gen, 0);
    step = 1'b0; run = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
